// File: rtl/seg_pkg.sv
// Shared widths and active-low segment patterns {a,b,c,d,e,f,g} for the scanned
// 7-segment display.
package seg_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'h01;
    localparam seg_t SEG_1     = 7'h4F;
    localparam seg_t SEG_2     = 7'h12;
    localparam seg_t SEG_3     = 7'h06;
    localparam seg_t SEG_4     = 7'h4C;
    localparam seg_t SEG_5     = 7'h24;
    localparam seg_t SEG_6     = 7'h20;
    localparam seg_t SEG_7     = 7'h0F;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h0C;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h60;
    localparam seg_t SEG_C     = 7'h31;
    localparam seg_t SEG_D     = 7'h42;
    localparam seg_t SEG_E     = 7'h30;
    localparam seg_t SEG_F     = 7'h38;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h7E;

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-segment decoder. Define SEG_SCAN_HEX_EN to show A..F for
// nibbles 10..15; otherwise those nibbles show a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (nib)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
`ifdef SEG_SCAN_HEX_EN
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
`endif
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with frame-synchronous double buffering and optional
// leading-zero blanking. Hex glyphs are enabled with SEG_SCAN_HEX_EN (see seg_decode).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 500000,
    parameter bit          BLANK_LZ   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [NIB_W*NUM_DIGITS-1:0]   din,
    output logic [SEG_W-1:0]              seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int unsigned DIN_W = NIB_W * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic [DIN_W-1:0]      shadow;
    logic [DIN_W-1:0]      disp;
    logic                  pending;
    logic                  tick_c;
    logic                  wrap_c;
    logic [NIB_W-1:0]      nib_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic                  zero_above_c;
    logic                  blank_c;
    logic [SEG_W-1:0]      dec_c;

    assign tick_c = en && (presc == CNT_LAST);
    assign wrap_c = tick_c && (idx == IDX_LAST);

    // Prescaler and scan index; both parked at zero while disabled so scanning
    // restarts with a full slot on digit 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick_c) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // Shadow/display buffering: a staged value only becomes visible at a frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (wrap_c && pending) begin
                disp <= shadow;
            end
            if (load) begin
                shadow  <= din;
                pending <= 1'b1;
            end else if (wrap_c) begin
                pending <= 1'b0;
            end
        end
    end

    // Digit select and leading-zero detection (lz_c[k]: digit k and all above are zero).
    always_comb begin
        nib_c        = '0;
        an_c         = '1;
        lz_c         = '0;
        zero_above_c = 1'b1;
        blank_c      = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above_c = zero_above_c && (disp[NIB_W*k +: NIB_W] == '0);
            lz_c[k]      = zero_above_c;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_c   = disp[NIB_W*k +: NIB_W];
                an_c[k] = 1'b0;
                blank_c = BLANK_LZ && (k != 0) && lz_c[k];
            end
        end
    end

    seg_decode u_decode (
        .nib   (nib_c),
        .seg_c (dec_c)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= blank_c ? SEG_BLANK : dec_c;
            an         <= an_c;
            frame_done <= wrap_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display (NUM_DIGITS=4, DIV=4), with a
// second instance using leading-zero blanking. Honours SEG_SCAN_HEX_EN.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic        load_lz;
    logic [15:0] din;
    logic [15:0] din_lz;
    logic [6:0]  seg;
    logic [6:0]  seg_lz;
    logic [3:0]  an;
    logic [3:0]  an_lz;
    logic        frame_done;
    logic        frame_done_lz;

    int          checks   = 0;
    int          failures = 0;
    int          n        = 0;
    logic [15:0] disp_a;
    logic [15:0] disp_b;

    always #5 clk = ~clk;

    seg_scan_display #(.NUM_DIGITS(4), .DIV(4), .BLANK_LZ(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .din        (din),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    seg_scan_display #(.NUM_DIGITS(4), .DIV(4), .BLANK_LZ(1'b1)) dut_lz (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load_lz),
        .din        (din_lz),
        .seg        (seg_lz),
        .an         (an_lz),
        .frame_done (frame_done_lz)
    );

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'h01;
            4'h1: return 7'h4F;
            4'h2: return 7'h12;
            4'h3: return 7'h06;
            4'h4: return 7'h4C;
            4'h5: return 7'h24;
            4'h6: return 7'h20;
            4'h7: return 7'h0F;
            4'h8: return 7'h00;
            4'h9: return 7'h0C;
`ifdef SEG_SCAN_HEX_EN
            4'hA: return 7'h08;
            4'hB: return 7'h60;
            4'hC: return 7'h31;
            4'hD: return 7'h42;
            4'hE: return 7'h30;
            4'hF: return 7'h38;
`endif
            default: return 7'h7E;
        endcase
    endfunction

    function automatic logic [6:0] lz_seg(input logic [15:0] d, input int slot);
        if (slot > 0 && (d >> (4 * slot)) == 16'h0) return 7'h7F;
        return dec(d[4*slot +: 4]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
        end
    endtask

    // One scanning cycle: n counts cycles since scanning (re)started.
    task automatic tick_chk();
        int         slot;
        logic [3:0] exp_an;
        n++;
        @(posedge clk);
        #1;
        slot   = ((n - 1) / 4) % 4;
        exp_an = ~(4'b0001 << slot);
        check("an",          16'(an),            16'(exp_an));
        check("seg",         16'(seg),           16'(dec(disp_a[4*slot +: 4])));
        check("frame_done",  16'(frame_done),    16'(n % 16 == 0));
        check("an_lz",       16'(an_lz),         16'(exp_an));
        check("seg_lz",      16'(seg_lz),        16'(lz_seg(disp_b, slot)));
        check("frame_done_lz", 16'(frame_done_lz), 16'(n % 16 == 0));
    endtask

    task automatic blank_chk();
        @(posedge clk);
        #1;
        check("seg_off",    16'(seg),           16'h007F);
        check("an_off",     16'(an),            16'h000F);
        check("fd_off",     16'(frame_done),    16'h0000);
        check("seg_lz_off", 16'(seg_lz),        16'h007F);
        check("an_lz_off",  16'(an_lz),         16'h000F);
        check("fd_lz_off",  16'(frame_done_lz), 16'h0000);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        load_lz = 1'b0;
        din     = 16'h0;
        din_lz  = 16'h0;
        disp_a  = 16'h0;
        disp_b  = 16'h0;

        // reset for three cycles
        repeat (3) blank_chk();
        rst     = 1'b0;
        en      = 1'b1;
        load_lz = 1'b1;
        din_lz  = 16'h0050;
        tick_chk();
        load_lz = 1'b0;
        while (n < 16) tick_chk();
        disp_b = 16'h0050;
        while (n < 36) tick_chk();

        // mid-frame load is deferred to the next wrap
        load = 1'b1;
        din  = 16'h1234;
        tick_chk();
        load = 1'b0;
        while (n < 48) tick_chk();
        disp_a = 16'h1234;
        while (n < 52) tick_chk();

        // stage 5678, then load 1111 on the wrap tick itself
        load = 1'b1;
        din  = 16'h5678;
        tick_chk();
        load = 1'b0;
        while (n < 63) tick_chk();
        load = 1'b1;
        din  = 16'h1111;
        tick_chk();
        load = 1'b0;
        disp_a = 16'h5678;
        while (n < 80) tick_chk();
        disp_a = 16'h1111;
        while (n < 100) tick_chk();

        // nibbles above 9
        load = 1'b1;
        din  = 16'h00AF;
        tick_chk();
        load = 1'b0;
        while (n < 112) tick_chk();
        disp_a = 16'h00AF;
        while (n < 134) tick_chk();

        // enable dropped mid-frame for five cycles
        en = 1'b0;
        repeat (5) blank_chk();
        en = 1'b1;
        n  = 0;
        repeat (20) tick_chk();

        // staged value and a load during reset are both lost
        load = 1'b1;
        din  = 16'h9999;
        tick_chk();
        load = 1'b0;
        tick_chk();
        rst  = 1'b1;
        load = 1'b1;
        din  = 16'h8888;
        blank_chk();
        load = 1'b0;
        blank_chk();
        rst    = 1'b0;
        n      = 0;
        disp_a = 16'h0;
        disp_b = 16'h0;
        repeat (20) tick_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
